// File: rtl/ula_sequenciador_pkg.sv
// ula_sequenciador_pkg: opcodes, FSM states and widths shared by the sequencer, its FIFO and the bench
package ula_sequenciador_pkg;
  localparam int ULA_RES_W = 9;
  localparam int CMD_W = 19;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NEGA = 3'd6;
  localparam logic [2:0] OP_NEGB = 3'd7;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/ula_sequenciador_if.sv
// ula_sequenciador_if: command, ALU-pin and response bundle; ULA_SEQ_FLAGS_EN adds rsp_zero/rsp_carry
interface ula_sequenciador_if;
  import ula_sequenciador_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic alu_en;
  logic [ULA_RES_W-1:0] alu_s;
  logic rsp_valid;
  logic rsp_ready;
  logic [ULA_RES_W-1:0] rsp_data;
  logic busy;
`ifdef ULA_SEQ_FLAGS_EN
  logic rsp_zero;
  logic rsp_carry;
`endif
  modport slave(
    input cmd_valid, cmd_a, cmd_b, cmd_op, alu_s, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_en, rsp_valid, rsp_data, busy
`ifdef ULA_SEQ_FLAGS_EN
    , output rsp_zero, rsp_carry
`endif
  );
  modport master(
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_s, rsp_ready,
    input cmd_ready, alu_a, alu_b, alu_opcode, alu_en, rsp_valid, rsp_data, busy
`ifdef ULA_SEQ_FLAGS_EN
    , input rsp_zero, rsp_carry
`endif
  );
endinterface

// File: rtl/ula_cmd_fifo.sv
// ula_cmd_fifo: DEPTH x W synchronous FIFO with sync CLR, guarded push/pop and occupancy count
module ula_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19
) (
  input  logic                     clk,
  input  logic                     CLR,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr_en, rd_en;
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (CLR) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: queues ALU commands, issues one at a time, waits ALU_LAT, returns result.
// Define ULA_SEQ_FLAGS_EN to add the registered rsp_zero/rsp_carry outputs.
module ula_sequenciador
  import ula_sequenciador_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ALU_LAT = 4
) (
  input logic clk,
  input logic CLR,
  ula_sequenciador_if.slave bus
);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  localparam int NW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [ULA_RES_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic pop, full, empty;
  logic [NW-1:0] count;
  logic [CMD_W-1:0] head;
  ula_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .CLR(CLR),
    .push_i(bus.cmd_valid),
    .pop_i(pop),
    .wdata_i({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
`ifdef ULA_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_carry = data_q[ULA_RES_W-1];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    data_d = data_q;
    valid_d = valid_q;
    pop = 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
    zero_d = zero_q;
`endif
    unique case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        {a_d, b_d, op_d} = head;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = CW'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        data_d = bus.alu_s;
        valid_d = 1'b1;
`ifdef ULA_SEQ_FLAGS_EN
        zero_d = bus.alu_s[7:0] == 8'h00;
`endif
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      RESP: if (bus.rsp_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
      zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      data_q <= data_d;
      valid_q <= valid_d;
`ifdef ULA_SEQ_FLAGS_EN
      zero_q <= zero_d;
`endif
    end
  end
  assign bus.cmd_ready = !full;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.alu_en = state_q == ISSUE;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data = data_q;
  assign bus.busy = state_q != IDLE || count != '0;
endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: directed + random commands checked by a push-order scoreboard and a timed ALU model
module tb_ula_sequenciador;
  import ula_sequenciador_pkg::*;
  localparam int DEPTH = 4;
  localparam int ALU_LAT = 4;
  logic clk = 1'b0;
  logic CLR = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  ula_sequenciador_if bus();
  ula_sequenciador #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (.clk(clk), .CLR(CLR), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      OP_ADD: return {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: return {1'b0, a} - {1'b0, b};
      OP_AND: return {1'b0, a & b};
      OP_OR: return {1'b0, a | b};
      OP_XOR: return {1'b0, a ^ b};
      OP_NEGA: return 9'h000 - {1'b0, a};
      default: return 9'h000 - {1'b0, b};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ALU stand-in: result appears ALU_LAT cycles after the alu_en cycle, inverted garbage before that
  logic [8:0] alu_res = '0;
  int alu_age = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.alu_en) begin
      alu_res <= alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);
      alu_age <= 0;
    end else if (alu_age < 1000) alu_age <= alu_age + 1;
  end
  assign bus.alu_s = (alu_age >= ALU_LAT - 1) ? alu_res : ~alu_res;

  logic [8:0] exp_q[$];
  int rise_q[$];
  int en_cnt = 0;
  int en_dbl = 0;
  logic prev_en = 1'b0;
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (CLR) begin
      exp_q.delete();
      prev_en = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(alu_f(bus.cmd_a, bus.cmd_b, bus.cmd_op));
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("rsp_data", bus.rsp_data, e);
`ifdef ULA_SEQ_FLAGS_EN
          chk("rsp_zero", bus.rsp_zero, e[7:0] == 8'h00);
          chk("rsp_carry", bus.rsp_carry, e[8]);
`endif
        end
      end
      if (bus.alu_en) begin
        en_cnt++;
        if (prev_en) en_dbl++;
      end
      if (bus.rsp_valid && !prev_rv) rise_q.push_back(cyc);
      prev_en = bus.alu_en;
      prev_rv = bus.rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", n < 200, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_rand();
    push(8'($urandom), 8'($urandom), 3'($urandom_range(7)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.rsp_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 500, 1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_alu_en"}, bus.alu_en, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_op"}, bus.alu_opcode, 0);
    chk({tag, "_busy"}, bus.busy, 0);
`ifdef ULA_SEQ_FLAGS_EN
    chk({tag, "_zero"}, bus.rsp_zero, 0);
    chk({tag, "_carry"}, bus.rsp_carry, 0);
`endif
  endtask

  initial begin
    int lat;
    logic [7:0] a0, b0;
    logic [2:0] op0;
    logic [8:0] d0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    CLR = 1'b0;
    chk_reset("rst");
    // reset in the middle of WAIT drops the command for good
    push(8'h12, 8'h34, OP_XOR);
    repeat (3) tick();
    chk("midwait_busy", bus.busy, 1);
    CLR = 1'b1;
    tick();
    tick();
    chk_reset("clr");
    CLR = 1'b0;
    rise_q.delete();
    repeat (15) tick();
    chk("clr_no_rsp", rise_q.size(), 0);
    // single op and latency
    bus.rsp_ready = 1'b1;
    push(8'h0F, 8'h01, OP_ADD);
    wait_rsp(lat);
    chk("single_lat", lat, ALU_LAT + 2);
    chk("single_data", bus.rsp_data, 9'h010);
    wait_idle();
    // carry result
    push(8'hFF, 8'h01, OP_ADD);
    wait_rsp(lat);
    chk("carry_lat", lat, ALU_LAT + 2);
    chk("carry_data", bus.rsp_data, 9'h100);
`ifdef ULA_SEQ_FLAGS_EN
    chk("carry_zero", bus.rsp_zero, 1);
    chk("carry_carry", bus.rsp_carry, 1);
`endif
    wait_idle();
    // backpressure in RESP
    bus.rsp_ready = 1'b0;
    a0 = 8'($urandom);
    b0 = 8'($urandom);
    op0 = 3'($urandom_range(7));
    push(a0, b0, op0);
    push_rand();
    wait_rsp(lat);
    chk("bp_rsp_seen", lat < 50, 1);
    d0 = alu_f(a0, b0, op0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, d0);
      chk("bp_alu_en", bus.alu_en, 0);
      chk("bp_alu_a", bus.alu_a, a0);
      chk("bp_alu_op", bus.alu_opcode, op0);
    end
    bus.rsp_ready = 1'b1;
    wait_idle();
    // FIFO full: one in the ALU plus DEPTH queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_rand();
    chk("full_ready", bus.cmd_ready, 0);
    a0 = 8'($urandom);
    b0 = 8'($urandom);
    op0 = 3'($urandom_range(7));
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a0;
    bus.cmd_b = b0;
    bus.cmd_op = op0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    push(a0, b0, op0);
    wait_idle();
    // streaming
    en_cnt = 0;
    en_dbl = 0;
    rise_q.delete();
    for (int i = 0; i < 8; i++) push_rand();
    wait_idle();
    chk("stream_en_cnt", en_cnt, 8);
    chk("stream_en_dbl", en_dbl, 0);
    chk("stream_rsp_cnt", rise_q.size(), 8);
    for (int i = 1; i < rise_q.size(); i++) chk("stream_space", rise_q[i] - rise_q[i-1], ALU_LAT + 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
